// File: rtl/execute_forwarding_history.sv
// Execute-stage forwarding history: keeps the last DEPTH GR writebacks newest-first,
// serves parallel newest-match lookups and holds a registered stack-pointer copy.
module execute_forwarding_history #(
    parameter int DATA_W       = 32,
    parameter int DEST_W       = 5,
    parameter int DEPTH        = 4,
    parameter int LOOKUP_PORTS = 2,
    parameter int BYPASS       = 0
) (
    input  logic                           iCLOCK,
    input  logic                           inRESET,
    input  logic                           iRESET_SYNC,
    input  logic                           iWB_GR_VALID,
    input  logic [DATA_W-1:0]              iWB_GR_DATA,
    input  logic [DEST_W-1:0]              iWB_GR_DEST,
    input  logic                           iWB_GR_DEST_SYSREG,
    input  logic                           iWB_SPR_VALID,
    input  logic [DATA_W-1:0]              iWB_SPR_DATA,
    input  logic                           iWB_AUTO_SPR_VALID,
    input  logic [DATA_W-1:0]              iWB_AUTO_SPR_DATA,
    input  logic [DATA_W-1:0]              iCUUR_SPR_DATA,
    input  logic [LOOKUP_PORTS*DEST_W-1:0] iLK_DEST,
    input  logic [LOOKUP_PORTS-1:0]        iLK_SYSREG,
    output logic [LOOKUP_PORTS-1:0]        oLK_HIT,
    output logic [LOOKUP_PORTS*DATA_W-1:0] oLK_DATA,
    output logic                           oFDR_GR_VALID,
    output logic [DATA_W-1:0]              oFDR_GR_DATA,
    output logic [DEST_W-1:0]              oFDR_GR_DEST,
    output logic                           oFDR_GR_DEST_SYSREG,
    output logic [3:0]                     oFDR_COUNT,
    output logic                           oFDR_SPR_VALID,
    output logic [DATA_W-1:0]              oFDR_SPR_DATA,
    output logic [1:0]                     oFDR_SPR_SRC
);

    localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

    typedef enum logic [1:0] {
        SRC_NONE     = 2'd0,
        SRC_EXPLICIT = 2'd1,
        SRC_AUTO     = 2'd2,
        SRC_CURRENT  = 2'd3
    } spr_src_t;

    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0][DEST_W-1:0] ent_dest;
    logic [DEPTH-1:0]             ent_sysreg;
    logic [3:0]                   count;
    spr_src_t                     spr_src;

    // Entry 0 is always the newest writeback; the oldest falls off the end.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            ent_valid  <= '0;
            ent_data   <= '0;
            ent_dest   <= '0;
            ent_sysreg <= '0;
            count      <= '0;
        end else if (iRESET_SYNC) begin
            ent_valid  <= '0;
            ent_data   <= '0;
            ent_dest   <= '0;
            ent_sysreg <= '0;
            count      <= '0;
        end else if (iWB_GR_VALID) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                ent_valid[i]  <= ent_valid[i-1];
                ent_data[i]   <= ent_data[i-1];
                ent_dest[i]   <= ent_dest[i-1];
                ent_sysreg[i] <= ent_sysreg[i-1];
            end
            ent_valid[0]  <= 1'b1;
            ent_data[0]   <= iWB_GR_DATA;
            ent_dest[0]   <= iWB_GR_DEST;
            ent_sysreg[0] <= iWB_GR_DEST_SYSREG;
            if (count != DEPTH_CNT) begin
                count <= count + 4'd1;
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            oFDR_SPR_VALID <= 1'b0;
            oFDR_SPR_DATA  <= '0;
            spr_src        <= SRC_NONE;
        end else if (iRESET_SYNC) begin
            oFDR_SPR_VALID <= 1'b0;
            oFDR_SPR_DATA  <= '0;
            spr_src        <= SRC_NONE;
        end else begin
            oFDR_SPR_VALID <= 1'b1;
            if (iWB_SPR_VALID) begin
                oFDR_SPR_DATA <= iWB_SPR_DATA;
                spr_src       <= SRC_EXPLICIT;
            end else if (iWB_AUTO_SPR_VALID) begin
                oFDR_SPR_DATA <= iWB_AUTO_SPR_DATA;
                spr_src       <= SRC_AUTO;
            end else begin
                oFDR_SPR_DATA <= iCUUR_SPR_DATA;
                spr_src       <= SRC_CURRENT;
            end
        end
    end

    // Scan oldest to newest so the newest match overwrites; the bypass is applied last.
    always_comb begin
        oLK_HIT  = '0;
        oLK_DATA = '0;
        for (int k = 0; k < LOOKUP_PORTS; k++) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (ent_valid[i] && (ent_dest[i] == iLK_DEST[k*DEST_W +: DEST_W])
                    && (ent_sysreg[i] == iLK_SYSREG[k])) begin
                    oLK_HIT[k]                   = 1'b1;
                    oLK_DATA[k*DATA_W +: DATA_W] = ent_data[i];
                end
            end
            if ((BYPASS != 0) && iWB_GR_VALID
                && (iWB_GR_DEST == iLK_DEST[k*DEST_W +: DEST_W])
                && (iWB_GR_DEST_SYSREG == iLK_SYSREG[k])) begin
                oLK_HIT[k]                   = 1'b1;
                oLK_DATA[k*DATA_W +: DATA_W] = iWB_GR_DATA;
            end
        end
    end

    assign oFDR_GR_VALID       = ent_valid[0];
    assign oFDR_GR_DATA        = ent_data[0];
    assign oFDR_GR_DEST        = ent_dest[0];
    assign oFDR_GR_DEST_SYSREG = ent_sysreg[0];
    assign oFDR_COUNT          = count;
    assign oFDR_SPR_SRC        = spr_src;

endmodule

// File: tb/tb_execute_forwarding_history.sv
// Directed bench for execute_forwarding_history; a BYPASS=0 and a BYPASS=1 instance share
// the same stimulus so the bypass difference is visible side by side.
module tb_execute_forwarding_history;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync_rst;
    logic        gr_valid;
    logic [31:0] gr_data;
    logic [4:0]  gr_dest;
    logic        gr_sys;
    logic        spr_valid;
    logic [31:0] spr_data;
    logic        auto_valid;
    logic [31:0] auto_data;
    logic [31:0] cur_spr;
    logic [9:0]  lk_dest;
    logic [1:0]  lk_sys;

    logic [1:0]  a_hit, b_hit;
    logic [63:0] a_data, b_data;
    logic        a_gr_valid, b_gr_valid;
    logic [31:0] a_gr_data, b_gr_data;
    logic [4:0]  a_gr_dest, b_gr_dest;
    logic        a_gr_sys, b_gr_sys;
    logic [3:0]  a_count, b_count;
    logic        a_spr_valid, b_spr_valid;
    logic [31:0] a_spr_data, b_spr_data;
    logic [1:0]  a_spr_src, b_spr_src;

    int total_checks = 0;
    int passed_checks = 0;

    always #5 clk = ~clk;

    execute_forwarding_history #(.DATA_W(32), .DEST_W(5), .DEPTH(4), .LOOKUP_PORTS(2), .BYPASS(0)) dut_a (
        .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(sync_rst),
        .iWB_GR_VALID(gr_valid), .iWB_GR_DATA(gr_data), .iWB_GR_DEST(gr_dest),
        .iWB_GR_DEST_SYSREG(gr_sys), .iWB_SPR_VALID(spr_valid), .iWB_SPR_DATA(spr_data),
        .iWB_AUTO_SPR_VALID(auto_valid), .iWB_AUTO_SPR_DATA(auto_data), .iCUUR_SPR_DATA(cur_spr),
        .iLK_DEST(lk_dest), .iLK_SYSREG(lk_sys), .oLK_HIT(a_hit), .oLK_DATA(a_data),
        .oFDR_GR_VALID(a_gr_valid), .oFDR_GR_DATA(a_gr_data), .oFDR_GR_DEST(a_gr_dest),
        .oFDR_GR_DEST_SYSREG(a_gr_sys), .oFDR_COUNT(a_count), .oFDR_SPR_VALID(a_spr_valid),
        .oFDR_SPR_DATA(a_spr_data), .oFDR_SPR_SRC(a_spr_src)
    );

    execute_forwarding_history #(.DATA_W(32), .DEST_W(5), .DEPTH(4), .LOOKUP_PORTS(2), .BYPASS(1)) dut_b (
        .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(sync_rst),
        .iWB_GR_VALID(gr_valid), .iWB_GR_DATA(gr_data), .iWB_GR_DEST(gr_dest),
        .iWB_GR_DEST_SYSREG(gr_sys), .iWB_SPR_VALID(spr_valid), .iWB_SPR_DATA(spr_data),
        .iWB_AUTO_SPR_VALID(auto_valid), .iWB_AUTO_SPR_DATA(auto_data), .iCUUR_SPR_DATA(cur_spr),
        .iLK_DEST(lk_dest), .iLK_SYSREG(lk_sys), .oLK_HIT(b_hit), .oLK_DATA(b_data),
        .oFDR_GR_VALID(b_gr_valid), .oFDR_GR_DATA(b_gr_data), .oFDR_GR_DEST(b_gr_dest),
        .oFDR_GR_DEST_SYSREG(b_gr_sys), .oFDR_COUNT(b_count), .oFDR_SPR_VALID(b_spr_valid),
        .oFDR_SPR_DATA(b_spr_data), .oFDR_SPR_SRC(b_spr_src)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Advance one clock and land just after the edge so outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] dest, input logic sys, input logic [31:0] data);
        gr_valid = 1'b1;
        gr_dest  = dest;
        gr_sys   = sys;
        gr_data  = data;
        tick();
        gr_valid = 1'b0;
    endtask

    task automatic setLookup(input logic [4:0] d0, input logic s0, input logic [4:0] d1, input logic s1);
        lk_dest = {d1, d0};
        lk_sys  = {s1, s0};
        #1;
    endtask

    initial begin
        rst_n = 1'b0; sync_rst = 1'b0;
        gr_valid = 1'b0; gr_data = '0; gr_dest = '0; gr_sys = 1'b0;
        spr_valid = 1'b0; spr_data = '0; auto_valid = 1'b0; auto_data = '0;
        cur_spr = 32'h1000; lk_dest = '0; lk_sys = '0;

        #12;
        checkOutput("reset_count", 64'(a_count), 64'd0);
        checkOutput("reset_hit", 64'({b_hit, a_hit}), 64'd0);
        checkOutput("reset_lkdata", a_data, 64'd0);
        checkOutput("reset_spr", 64'({a_spr_valid, a_spr_src}), 64'd0);
        checkOutput("reset_gr_valid", 64'(a_gr_valid), 64'd0);
        rst_n = 1'b1;

        tick();
        checkOutput("idle_spr_src", 64'(a_spr_src), 64'd3);
        checkOutput("idle_spr_data", 64'(a_spr_data), 64'h1000);
        checkOutput("idle_spr_valid", 64'(a_spr_valid), 64'd1);
        checkOutput("idle_count", 64'(a_count), 64'd0);

        applyStimulus(5'd3, 1'b0, 32'h11);
        applyStimulus(5'd5, 1'b0, 32'h22);
        applyStimulus(5'd3, 1'b0, 32'h33);
        setLookup(5'd3, 1'b0, 5'd5, 1'b0);
        checkOutput("dup_hit", 64'(a_hit), 64'b11);
        checkOutput("dup_data", a_data, {32'h22, 32'h33});
        checkOutput("dup_count", 64'(a_count), 64'd3);
        checkOutput("newest_entry", 64'({a_gr_valid, a_gr_dest, a_gr_data}), {1'b1, 5'd3, 32'h33});

        for (int r = 1; r <= 5; r++) applyStimulus(5'(r), 1'b0, 32'(r));
        setLookup(5'd1, 1'b0, 5'd2, 1'b0);
        checkOutput("evict_hit", 64'(a_hit), 64'b10);
        checkOutput("evict_data", a_data, {32'h2, 32'h0});
        checkOutput("sat_count", 64'(a_count), 64'd4);

        applyStimulus(5'd7, 1'b1, 32'hAA);
        setLookup(5'd7, 1'b0, 5'd7, 1'b1);
        checkOutput("sysreg_hit", 64'(a_hit), 64'b10);
        checkOutput("sysreg_data", a_data, {32'hAA, 32'h0});
        checkOutput("sysreg_flag", 64'(a_gr_sys), 64'd1);

        applyStimulus(5'd4, 1'b0, 32'h10);
        gr_valid = 1'b1; gr_dest = 5'd4; gr_sys = 1'b0; gr_data = 32'h20;
        setLookup(5'd4, 1'b0, 5'd5, 1'b0);
        checkOutput("nobypass_data0", 64'(a_data[31:0]), 64'h10);
        checkOutput("bypass_data0", 64'(b_data[31:0]), 64'h20);
        checkOutput("bypass_hit", 64'(b_hit), 64'b11);
        tick();
        gr_valid = 1'b0;
        #1;
        checkOutput("committed_data0", 64'({b_data[31:0], a_data[31:0]}), {32'h20, 32'h20});
        checkOutput("oldest_r5", 64'(a_data[63:32]), 64'h5);

        spr_valid = 1'b1; spr_data = 32'hBEEF; auto_valid = 1'b1; auto_data = 32'hCAFE;
        applyStimulus(5'd9, 1'b0, 32'h99);
        checkOutput("spr_explicit", 64'({a_spr_valid, a_spr_src, a_spr_data}), {1'b1, 2'd1, 32'hBEEF});
        checkOutput("spr_with_gr", 64'({a_gr_dest, a_gr_data}), {5'd9, 32'h99});
        spr_valid = 1'b0;
        tick();
        checkOutput("spr_auto", 64'({a_spr_valid, a_spr_src, a_spr_data}), {1'b1, 2'd2, 32'hCAFE});
        auto_valid = 1'b0;
        tick();
        checkOutput("spr_current", 64'({b_spr_valid, b_spr_src, b_spr_data}), {1'b1, 2'd3, 32'h1000});

        sync_rst = 1'b1; spr_valid = 1'b1;
        applyStimulus(5'd2, 1'b0, 32'h77);
        sync_rst = 1'b0; spr_valid = 1'b0;
        setLookup(5'd2, 1'b0, 5'd9, 1'b0);
        checkOutput("sync_count", 64'({b_count, a_count}), 64'd0);
        checkOutput("sync_hit", 64'({b_hit, a_hit}), 64'd0);
        checkOutput("sync_spr", 64'({a_spr_valid, a_spr_src, a_spr_data}), 64'd0);

        applyStimulus(5'd6, 1'b0, 32'h66);
        setLookup(5'd6, 1'b0, 5'd6, 1'b0);
        checkOutput("pre_async_count", 64'(a_count), 64'd1);
        checkOutput("pre_async_hit", 64'(a_hit), 64'b11);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_count", 64'(a_count), 64'd0);
        checkOutput("async_hit", 64'({b_hit, a_hit}), 64'd0);
        checkOutput("async_gr", 64'({a_gr_valid, a_gr_data}), 64'd0);
        checkOutput("async_spr", 64'({a_spr_valid, a_spr_src}), 64'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_async_spr", 64'(a_spr_src), 64'd3);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/execute_forwarding_history.md
Name: execute_forwarding_history

Overview:
- Parametrised successor to the single-entry execute-stage forwarding register.
- Keeps the last DEPTH general-register writebacks in a newest-first history.
- Serves LOOKUP_PORTS parallel operand lookups with newest-match priority.
- Keeps a registered stack-pointer forwarding copy and reports which source it came from.

Parameters:
- DATA_W, 32: writeback data width.
- DEST_W, 5: destination register index width.
- DEPTH, 4: history entries, legal range 1..8.
- LOOKUP_PORTS, 2: parallel operand lookup ports, legal range 1..4.
- BYPASS, 0: 1 = the lookup also matches the same-cycle writeback input, ahead of the history.

Ports:
- iCLOCK  in  1  clock.
- inRESET  in  1  reset, asynchronous, active-low.
- iRESET_SYNC  in  1  synchronous clear.
- iWB_GR_VALID  in  1  GR writeback strobe.
- iWB_GR_DATA  in  DATA_W  GR writeback data.
- iWB_GR_DEST  in  DEST_W  GR destination index.
- iWB_GR_DEST_SYSREG  in  1  destination is a system register.
- iWB_SPR_VALID  in  1  explicit SPR writeback.
- iWB_SPR_DATA  in  DATA_W  explicit SPR data.
- iWB_AUTO_SPR_VALID  in  1  automatic SPR update (push/pop).
- iWB_AUTO_SPR_DATA  in  DATA_W  automatic SPR data.
- iCUUR_SPR_DATA  in  DATA_W  architectural SPR value.
- iLK_DEST  in  LOOKUP_PORTS*DEST_W  lookup indices; port k is at [k*DEST_W +: DEST_W].
- iLK_SYSREG  in  LOOKUP_PORTS  lookup targets a system register.
- oLK_HIT  out  LOOKUP_PORTS  match found.
- oLK_DATA  out  LOOKUP_PORTS*DATA_W  matched data.
- oFDR_GR_VALID  out  1  newest entry valid.
- oFDR_GR_DATA  out  DATA_W  newest entry data.
- oFDR_GR_DEST  out  DEST_W  newest entry index.
- oFDR_GR_DEST_SYSREG  out  1  newest entry sysreg flag.
- oFDR_COUNT  out  4  number of valid entries, 0..DEPTH.
- oFDR_SPR_VALID  out  1  SPR copy valid.
- oFDR_SPR_DATA  out  DATA_W  SPR copy.
- oFDR_SPR_SRC  out  2  source of the SPR copy: 0 = none, 1 = explicit, 2 = auto, 3 = current.

Behaviour:
- Reset, inRESET low (async) or iRESET_SYNC high (sync) with identical effect:
  - all entries cleared to valid 0, data 0, dest 0, sysreg 0;
  - oFDR_COUNT = 0;
  - oFDR_SPR_VALID = 0, oFDR_SPR_DATA = 0, oFDR_SPR_SRC = 0;
  - all oLK_HIT = 0, all oLK_DATA = 0 (BYPASS=0);
  - iRESET_SYNC overrides a same-cycle iWB_GR_VALID and any SPR write.
- History shift: on a clock edge with iWB_GR_VALID = 1:
  - entry[i] <= entry[i-1] for i = 1..DEPTH-1;
  - entry[0] <= {1, data, dest, sysreg};
  - entry[DEPTH-1] is discarded;
  - oFDR_COUNT increments and saturates at DEPTH.
- With iWB_GR_VALID = 0 the history holds.
- Duplicate destinations are not collapsed; older copies stay but are shadowed by the lookup priority.
- oFDR_GR_* equal entry[0] (registered, one-cycle latency), matching the previous single-entry behaviour.
- Lookup is combinational, zero latency, identical for every port k:
  - An entry matches when valid = 1, dest == iLK_DEST[k] and sysreg == iLK_SYSREG[k].
  - Priority: same-cycle WB input (only when BYPASS = 1 and iWB_GR_VALID = 1) > entry[0] > ... > entry[DEPTH-1].
  - On a match, oLK_HIT[k] = 1 and oLK_DATA[k] = data of the highest-priority match.
  - On no match, oLK_HIT[k] = 0 and oLK_DATA[k] = 0.
  - Destination index 0 is not special; it forwards like any other index.
- SPR register, updated every non-reset cycle, with priority:
  - iWB_SPR_VALID: data = iWB_SPR_DATA, SRC = 1;
  - else iWB_AUTO_SPR_VALID: data = iWB_AUTO_SPR_DATA, SRC = 2;
  - else: data = iCUUR_SPR_DATA, SRC = 3.
  - oFDR_SPR_VALID <= 1 in all three branches. The auto path is valid, which fixes the older design where it reported invalid.
- GR and SPR paths are independent; a same-cycle GR and SPR write both take effect.

Test Plan:
- Reset then idle: oFDR_COUNT = 0, oLK_HIT = 0. After 1 clock, oFDR_SPR_SRC = 3 and oFDR_SPR_DATA = iCUUR_SPR_DATA (0x1000).
- Writes r3 = 0x11, r5 = 0x22, r3 = 0x33 on consecutive cycles; lookup port0 = r3, port1 = r5 -> hit = 2'b11, data0 = 0x33, data1 = 0x22, oFDR_COUNT = 3.
- DEPTH = 4, write r1..r5 with data 0x1..0x5 -> lookup r1 misses, lookup r2 hits 0x2, oFDR_COUNT saturates at 4.
- Write r7 with sysreg = 1 (0xAA), then lookup r7 with sysreg = 0 -> miss; lookup r7 with sysreg = 1 -> hit 0xAA.
- BYPASS = 1: history r4 = 0x10 and same-cycle WB r4 = 0x20 -> lookup r4 returns 0x20 that cycle. BYPASS = 0 -> returns 0x10.
- iWB_SPR_VALID with iWB_AUTO_SPR_VALID in the same cycle -> SRC = 1 with explicit data. Auto alone -> SRC = 2, VALID = 1. iRESET_SYNC during a GR write -> COUNT = 0, no hit. inRESET pulse mid-sequence clears everything asynchronously.
